sram_b: RTL and testbench

SRAM_B -- requirements
Module: sram_b

---
 rtl/sram_b.sv | 52 +++++
 tb/tb_sram_b.sv | 138 +++++++++++++
 2 files changed

// File: rtl/sram_b.sv
// sram_b: single-port synchronous RAM, 2**ADDR_W words x DATA_W bits.
// One shared address for read and write. The read port is write-first:
// on a write edge the output register takes the incoming data. The output
// register clears asynchronously on reset. The array is never reset, so
// reset does not disturb stored contents, and the array stays inferable
// as block RAM.
module sram_b #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              rpll_clk,
    input  logic              rst_n,
    input  logic              sram_B_we,
    input  logic [ADDR_W-1:0] sram_B_addr,
    input  logic [DATA_W-1:0] sram_B_din,
    output logic [DATA_W-1:0] sram_B_dout
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Storage array. It starts at all zeros at configuration time, and
    // reset never clears it.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    // A write only takes effect when reset is released at the sampling
    // edge. If reset drops between edges, the write already done stands.
    logic wr_en;

    // Qualify the write strobe with reset, so writes are ignored while reset is held.
    always_comb begin
        wr_en = sram_B_we & rst_n;
    end

    // Array write port: single word per edge, no reset, to allow block RAM inference.
    always_ff @(posedge rpll_clk) begin
        if (wr_en) begin
            mem[sram_B_addr] <= sram_B_din;
        end
    end

    // Output register: async clear, write-first on write edges, else registered read.
    always_ff @(posedge rpll_clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_B_dout <= '0;
        end else if (sram_B_we) begin
            sram_B_dout <= sram_B_din;
        end else begin
            sram_B_dout <= mem[sram_B_addr];
        end
    end

endmodule

// File: tb/tb_sram_b.sv
// tb_sram_b: self-checking bench for sram_b. A plain array plus an
// expected-output variable serve as the reference memory.
module tb_sram_b;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] exp_dout;

    sram_b #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .rpll_clk    (clk),
        .rst_n       (rst_n),
        .sram_B_we   (we),
        .sram_B_addr (addr),
        .sram_B_din  (din),
        .sram_B_dout (dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one cycle, update the model with the rules of the memory,
    // check just after the edge and again mid-cycle to confirm the output holds.
    task automatic cyc(input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input string tag);
        we   = w;
        addr = a;
        din  = d;
        @(posedge clk);
        if (!rst_n) begin
            exp_dout = '0;
        end else if (w) begin
            ref_mem[a] = d;
            exp_dout   = d;
        end else begin
            exp_dout = ref_mem[a];
        end
        #1;
        check(tag, dout, exp_dout);
        #4;
        check({tag, "_hold"}, dout, exp_dout);
    endtask

    initial begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        exp_dout = '0;
        we    = 1'b0;
        addr  = '0;
        din   = '0;
        rst_n = 1'b1;

        // Reset asserted away from any edge, with arbitrary inputs.
        #2;
        we    = 1'b1;
        addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
        din   = DATA_W'($urandom);
        rst_n = 1'b0;
        #1;
        check("rst_async", dout, 8'h00);
        for (int i = 0; i < 3; i++) begin
            cyc(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom), "rst_hold");
            check("rst_zero", dout, 8'h00);
        end
        rst_n = 1'b1;

        // Write then read at address 0.
        cyc(1'b1, 10'd0, 8'hA5, "wr0");
        cyc(1'b0, 10'd0, 8'h00, "rd0");
        check("rd0_lit", dout, 8'hA5);

        // Top address, write-first, neighbour unaffected.
        cyc(1'b1, 10'd1023, 8'h3C, "wr1023");
        check("wr1023_first", dout, 8'h3C);
        cyc(1'b0, 10'd1023, 8'h00, "rd1023");
        check("rd1023_lit", dout, 8'h3C);
        cyc(1'b0, 10'd1022, 8'h55, "rd1022");
        check("rd1022_lit", dout, 8'h00);

        // Overwrite on consecutive edges.
        cyc(1'b1, 10'd512, 8'h11, "wr512a");
        cyc(1'b1, 10'd512, 8'h22, "wr512b");
        cyc(1'b0, 10'd512, 8'h00, "rd512");
        check("rd512_lit", dout, 8'h22);

        // Reset preserves memory and blocks writes.
        cyc(1'b1, 10'd100, 8'h7E, "wr100");
        rst_n = 1'b0;
        #1;
        check("rst2_async", dout, 8'h00);
        cyc(1'b1, 10'd100, 8'hFF, "rst2_wr");
        cyc(1'b1, 10'd100, 8'hFF, "rst2_wr2");
        rst_n = 1'b1;
        cyc(1'b0, 10'd100, 8'h00, "rd100");
        check("rd100_lit", dout, 8'h7E);

        // Random regression: two write cycles then two read cycles per address.
        for (int i = 0; i < 1000; i++) begin
            ra = ADDR_W'($urandom_range(0, DEPTH - 1));
            rd = DATA_W'($urandom_range(0, 255));
            cyc(1'b1, ra, rd, "rnd_wr1");
            cyc(1'b1, ra, rd, "rnd_wr2");
            cyc(1'b0, ra, DATA_W'($urandom), "rnd_rd1");
            cyc(1'b0, ra, DATA_W'($urandom), "rnd_rd2");
            check("rnd_data", dout, rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
